// File: rtl/demux_rr.sv
`default_nettype none
// ============================================================================
//  Module   : demux_rr
//  Purpose  : Receive side of the lane-interleave link. Splits one serialized
//             valid/data stream alternately onto lane 0 and lane 1 through
//             registered outputs. Alternation restarts at lane 0 after reset.
//  Options  : DEMUX_CNT_EN - adds per-lane wrapping word counters
//             (cnt_0_c / cnt_1_c) and the CNT_W parameter.
//  Revision : 1.0 - initial release
// ============================================================================
module demux_rr #(
  parameter int WIDTH = 8
`ifdef DEMUX_CNT_EN
  ,
  parameter int CNT_W = 8
`endif
) (
  input  logic             clk2f,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in_c,
  input  logic             valid_in_c,
  output logic [WIDTH-1:0] data_out_0_c,
  output logic             valid_out_0_c,
  output logic [WIDTH-1:0] data_out_1_c,
  output logic             valid_out_1_c
`ifdef DEMUX_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt_0_c,
  output logic [CNT_W-1:0] cnt_1_c
`endif
);

  // One-hot encoding; any other pattern is treated as illegal.
  typedef enum logic [5:0] {
    ST_RESET  = 6'b000001,
    ST_INIT   = 6'b000010,
    ST_RX_0   = 6'b000100,
    ST_RX_1   = 6'b001000,
    ST_W_LST0 = 6'b010000,
    ST_W_LST1 = 6'b100000
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_take_0;
  logic   w_take_1;

  // State register; reset parks the FSM in ST_RESET.
  always_ff @(posedge clk2f) begin
    if (reset) begin
      r_state <= ST_RESET;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and lane steering. The first edge out of reset only moves to
  // ST_INIT, so a word presented on that edge is deliberately dropped.
  always_comb begin
    w_state_nxt = ST_RESET;
    w_take_0    = 1'b0;
    w_take_1    = 1'b0;
    case (r_state)
      ST_RESET: begin
        w_state_nxt = ST_INIT;
      end
      ST_INIT: begin
        if (valid_in_c) begin
          w_take_0    = 1'b1;
          w_state_nxt = ST_RX_0;
        end else begin
          w_state_nxt = ST_INIT;
        end
      end
      ST_RX_0: begin
        if (valid_in_c) begin
          w_take_1    = 1'b1;
          w_state_nxt = ST_RX_1;
        end else begin
          w_state_nxt = ST_W_LST0;
        end
      end
      ST_RX_1: begin
        if (valid_in_c) begin
          w_take_0    = 1'b1;
          w_state_nxt = ST_RX_0;
        end else begin
          w_state_nxt = ST_W_LST1;
        end
      end
      ST_W_LST0: begin
        if (valid_in_c) begin
          w_take_1    = 1'b1;
          w_state_nxt = ST_RX_1;
        end else begin
          w_state_nxt = ST_W_LST0;
        end
      end
      ST_W_LST1: begin
        if (valid_in_c) begin
          w_take_0    = 1'b1;
          w_state_nxt = ST_RX_0;
        end else begin
          w_state_nxt = ST_W_LST1;
        end
      end
      default: begin
        w_state_nxt = ST_RESET;
      end
    endcase
  end

  // Registered lane outputs; data is forced to zero when the lane is idle.
  always_ff @(posedge clk2f) begin
    if (reset) begin
      valid_out_0_c <= 1'b0;
      valid_out_1_c <= 1'b0;
      data_out_0_c  <= '0;
      data_out_1_c  <= '0;
    end else begin
      valid_out_0_c <= w_take_0;
      valid_out_1_c <= w_take_1;
      data_out_0_c  <= w_take_0 ? data_in_c : '0;
      data_out_1_c  <= w_take_1 ? data_in_c : '0;
    end
  end

`ifdef DEMUX_CNT_EN
  // Per-lane word counters, stepping on the edge that raises the lane valid.
  always_ff @(posedge clk2f) begin
    if (reset) begin
      cnt_0_c <= '0;
      cnt_1_c <= '0;
    end else begin
      if (w_take_0) begin
        cnt_0_c <= cnt_0_c + CNT_W'(1);
      end
      if (w_take_1) begin
        cnt_1_c <= cnt_1_c + CNT_W'(1);
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_demux_rr.sv
`default_nettype none
// ============================================================================
//  Module   : tb_demux_rr
//  Purpose  : Self-checking bench for demux_rr. A lane-alternation reference
//             model predicts every registered output after each clock edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_demux_rr;

  localparam int WIDTH = 8;
  localparam int CNT_W = 8;
  localparam int CNT_MOD = 1 << CNT_W;

  logic             clk2f;
  logic             reset;
  logic [WIDTH-1:0] data_in_c;
  logic             valid_in_c;
  logic [WIDTH-1:0] data_out_0_c;
  logic             valid_out_0_c;
  logic [WIDTH-1:0] data_out_1_c;
  logic             valid_out_1_c;
  logic [CNT_W-1:0] cnt_0_c;
  logic [CNT_W-1:0] cnt_1_c;

`ifdef DEMUX_CNT_EN
  demux_rr #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk2f         (clk2f),
    .reset         (reset),
    .data_in_c     (data_in_c),
    .valid_in_c    (valid_in_c),
    .data_out_0_c  (data_out_0_c),
    .valid_out_0_c (valid_out_0_c),
    .data_out_1_c  (data_out_1_c),
    .valid_out_1_c (valid_out_1_c),
    .cnt_0_c       (cnt_0_c),
    .cnt_1_c       (cnt_1_c)
  );
`else
  demux_rr #(.WIDTH(WIDTH)) dut (
    .clk2f         (clk2f),
    .reset         (reset),
    .data_in_c     (data_in_c),
    .valid_in_c    (valid_in_c),
    .data_out_0_c  (data_out_0_c),
    .valid_out_0_c (valid_out_0_c),
    .data_out_1_c  (data_out_1_c),
    .valid_out_1_c (valid_out_1_c)
  );
  assign cnt_0_c = '0;
  assign cnt_1_c = '0;
`endif

  initial clk2f = 1'b0;
  always #5 clk2f = ~clk2f;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model: which lane the next accepted word goes to, whether the
  // next edge is the post-reset edge that drops input, and expected outputs.
  int         m_lane = 0;
  bit         m_drop = 1'b1;
  logic       ev0 = 1'b0;
  logic       ev1 = 1'b0;
  logic [7:0] ed0 = '0;
  logic [7:0] ed1 = '0;
  int         mc0 = 0;
  int         mc1 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_edge(input logic rst, input logic v, input logic [7:0] d);
    ev0 = 1'b0; ev1 = 1'b0; ed0 = '0; ed1 = '0;
    if (rst) begin
      m_lane = 0; m_drop = 1'b1; mc0 = 0; mc1 = 0;
    end else if (m_drop) begin
      m_drop = 1'b0;
    end else if (v) begin
      if (m_lane == 0) begin
        ev0 = 1'b1; ed0 = d; mc0 = (mc0 + 1) % CNT_MOD;
      end else begin
        ev1 = 1'b1; ed1 = d; mc1 = (mc1 + 1) % CNT_MOD;
      end
      m_lane = 1 - m_lane;
    end
  endtask

  task automatic check_outputs();
    chk("valid0", 32'(valid_out_0_c), 32'(ev0));
    chk("valid1", 32'(valid_out_1_c), 32'(ev1));
    chk("data0",  32'(data_out_0_c),  32'(ed0));
    chk("data1",  32'(data_out_1_c),  32'(ed1));
    chk("onehot", 32'(valid_out_0_c & valid_out_1_c), 32'(0));
`ifdef DEMUX_CNT_EN
    chk("cnt0", 32'(cnt_0_c), 32'(mc0));
    chk("cnt1", 32'(cnt_1_c), 32'(mc1));
`endif
  endtask

  // One clock: drive on the falling edge, model the rising edge, sample after.
  task automatic step(input logic rst, input logic v, input logic [7:0] d);
    @(negedge clk2f);
    reset = rst; valid_in_c = v; data_in_c = d;
    @(posedge clk2f);
    model_edge(rst, v, d);
    #1;
    check_outputs();
  endtask

  initial begin
    reset = 1'b1; valid_in_c = 1'b0; data_in_c = '0;

    // Reset held with valid asserted: everything stays zero.
    step(1'b1, 1'b1, 8'h3C);
    step(1'b1, 1'b1, 8'h3D);
    step(1'b1, 1'b1, 8'h3E);

    // Release edge with a word present: it must be dropped.
    step(1'b0, 1'b1, 8'h5A);

    // Back-to-back stream alternates lane 0 / lane 1.
    step(1'b0, 1'b1, 8'hA1);
    chk("first_word_lane0", 32'(data_out_0_c), 32'h0000_00A1);
    step(1'b0, 1'b1, 8'hB2);
    step(1'b0, 1'b1, 8'hC3);
    step(1'b0, 1'b1, 8'hD4);
    chk("last_word_lane1", 32'(data_out_1_c), 32'h0000_00D4);
    step(1'b0, 1'b0, 8'hEE);

    // Idle gap does not disturb alternation.
    step(1'b0, 1'b1, 8'h11);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'(i + 8'h90));
    step(1'b0, 1'b1, 8'h22);
    chk("after_gap_lane1", 32'(data_out_1_c), 32'h0000_0022);
    step(1'b0, 1'b0, 8'h00);

    // Mid-stream reset discards the in-flight word; restart on lane 0.
    step(1'b0, 1'b1, 8'h01);
    step(1'b0, 1'b1, 8'h02);
    step(1'b1, 1'b1, 8'h03);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h04);
    chk("restart_lane0", 32'(data_out_0_c), 32'h0000_0004);
    step(1'b0, 1'b0, 8'h00);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
           8'($urandom));
    end

    // 512 back-to-back words from a clean reset: each lane sees 256.
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 512; i++) step(1'b0, 1'b1, 8'($urandom));
    step(1'b0, 1'b0, 8'h00);
`ifdef DEMUX_CNT_EN
    chk("cnt0_wrapped", 32'(cnt_0_c), 32'(0));
    chk("cnt1_wrapped", 32'(cnt_1_c), 32'(0));
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
